fc_par_layer: RTL and testbench

//  Runtime-programmable fully-connected layer: y = act(W*x [+ b]), W is MxN, x is N, y is M.

---
 rtl/fc_pkg.sv | 38 +++
 rtl/fc_mac_lane.sv | 84 ++++++++
 rtl/fc_par_layer.sv | 248 ++++++++++++++++++++++++
 tb/tb_fc_par_layer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and saturating arithmetic helpers for the parallel fully-connected layer.
package fc_pkg;

  typedef enum logic [2:0] {
    W_LOAD,
    X_LOAD,
    COMPUTE,
    OUT
  } fc_state_t;

  // Counter width for a given depth, never narrower than one bit.
  function automatic int clog2_depth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int t);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_mul(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int t);
    return sat_clamp(a * b, t);
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int t);
    return sat_clamp(a + b, t);
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: weight bank RAM, registered product, saturating accumulator, optional ReLU.
// With FC_BIAS_EN defined the lane also keeps one bias word per pass.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int N    = 6,
  parameter int T    = 16,
  parameter int GRPS = 3,
  parameter int R    = 1,
  parameter int AW   = clog2_depth(GRPS * N)
`ifdef FC_BIAS_EN
  , parameter int GW = clog2_depth(GRPS)
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrEn_i,
  input  logic [AW-1:0] wrAddr_i,
  input  logic [T-1:0]  wrData_i,
`ifdef FC_BIAS_EN
  input  logic          biasWrEn_i,
  input  logic [GW-1:0] biasWrIdx_i,
  input  logic [GW-1:0] biasSel_i,
`endif
  input  logic          rdEn_i,
  input  logic [AW-1:0] rdAddr_i,
  input  logic [T-1:0]  x_i,
  input  logic          accClr_i,
  output logic [T-1:0]  y_o
);

  localparam int DEPTH = GRPS * N;

  logic [T-1:0] mem [DEPTH];
  logic [T-1:0] rdData_q;
  logic [T-1:0] prod_q, prod_d;
  logic [T-1:0] acc_q, acc_d;
  logic [T-1:0] accInit;
  logic         rdValid_q;
  logic         prodValid_q;

`ifdef FC_BIAS_EN
  logic [T-1:0] bias_q [GRPS];

  always_ff @(posedge clk) begin
    if (biasWrEn_i) bias_q[biasWrIdx_i] <= wrData_i;
  end

  assign accInit = bias_q[biasSel_i];
`else
  assign accInit = '0;
`endif

  always_ff @(posedge clk) begin
    if (wrEn_i) mem[wrAddr_i] <= wrData_i;
    if (rdEn_i) rdData_q <= mem[rdAddr_i];
  end

  // x_i arrives registered alongside the RAM read, so it pairs with rdData_q.
  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    if (rdValid_q) prod_d = T'(sat_mul(64'(signed'(rdData_q)), 64'(signed'(x_i)), T));
    if (accClr_i) acc_d = accInit;
    else if (prodValid_q) acc_d = T'(sat_add(64'(signed'(acc_q)), 64'(signed'(prod_q)), T));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid_q   <= 1'b0;
      prodValid_q <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
    end else begin
      rdValid_q   <= rdEn_i;
      prodValid_q <= rdValid_q;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
    end
  end

  assign y_o = ((R != 0) && acc_q[T-1]) ? '0 : acc_q;

endmodule

// File: rtl/fc_par_layer.sv
// Runtime-programmable fully-connected layer with P parallel MAC lanes and a serial output stream.
// Optional FC_BIAS_EN: M bias words follow the weights and preload each accumulator.
module fc_par_layer
  import fc_pkg::*;
#(
  parameter int M = 6,
  parameter int N = 6,
  parameter int T = 16,
  parameter int P = 2,
  parameter int R = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [T-1:0] w_data,
  input  logic         input_valid,
  output logic         input_ready,
  input  logic [T-1:0] input_data,
  output logic         output_valid,
  input  logic         output_ready,
  output logic [T-1:0] output_data
);

  localparam int GRPS = M / P;
  localparam int AW   = clog2_depth(GRPS * N);
  localparam int GW   = clog2_depth(GRPS);
  localparam int LW   = clog2_depth(P);
  localparam int XW   = clog2_depth(N);
  localparam int CW   = clog2_depth(N + 2);

  localparam logic [XW-1:0] COL_LAST  = XW'(N - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(P - 1);
  localparam logic [GW-1:0] GRP_LAST  = GW'(GRPS - 1);
  localparam logic [CW-1:0] CNT_READS = CW'(N);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N + 1);

  fc_state_t     state_q, state_d;
  logic [XW-1:0] col_q, col_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [XW-1:0] xIdx_q, xIdx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] pass_q, pass_d;
  logic [LW-1:0] outLane_q, outLane_d;
  logic          outValid_q, outValid_d;
  logic [T-1:0]  outData_q, outData_d;
  logic [T-1:0]  xBuf_q [N];
  logic [T-1:0]  xCol_q;

  logic [P-1:0]  wrEn;
  logic [AW-1:0] wrAddr;
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic          xWrEn;
  logic          accClr;
  logic          rowDone;
  logic [LW-1:0] nextLane;
  logic [T-1:0]  laneY [P];

`ifdef FC_BIAS_EN
  logic          biasPhase_q, biasPhase_d;
  logic [P-1:0]  biasWrEn;
`endif

  assign wrAddr   = AW'(grp_q) * AW'(N) + AW'(col_q);
  assign rdEn     = (state_q == COMPUTE) && (cnt_q < CNT_READS);
  assign rdAddr   = AW'(pass_q) * AW'(N) + AW'(cnt_q[XW-1:0]);
  assign nextLane = outLane_q + LW'(1);

  // Weight words walk column, then lane bank, then row group; bias words reuse lane/group.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    lane_d      = lane_q;
    grp_d       = grp_q;
    xIdx_d      = xIdx_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    outLane_d   = outLane_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    w_ready     = 1'b0;
    input_ready = 1'b0;
    wrEn        = '0;
    xWrEn       = 1'b0;
    accClr      = 1'b0;
    rowDone     = 1'b0;
`ifdef FC_BIAS_EN
    biasPhase_d = biasPhase_q;
    biasWrEn    = '0;
`endif
    case (state_q)
      W_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
`ifdef FC_BIAS_EN
          if (biasPhase_q) biasWrEn[lane_q] = 1'b1;
          else wrEn[lane_q] = 1'b1;
          rowDone = biasPhase_q || (col_q == COL_LAST);
`else
          wrEn[lane_q] = 1'b1;
          rowDone = (col_q == COL_LAST);
`endif
          if (!rowDone) begin
            col_d = col_q + XW'(1);
          end else begin
            col_d = '0;
            if (lane_q != LANE_LAST) begin
              lane_d = lane_q + LW'(1);
            end else begin
              lane_d = '0;
              if (grp_q != GRP_LAST) begin
                grp_d = grp_q + GW'(1);
              end else begin
                grp_d = '0;
`ifdef FC_BIAS_EN
                if (biasPhase_q) begin
                  biasPhase_d = 1'b0;
                  state_d     = X_LOAD;
                end else begin
                  biasPhase_d = 1'b1;
                end
`else
                state_d = X_LOAD;
`endif
              end
            end
          end
        end
      end
      X_LOAD: begin
        input_ready = 1'b1;
        accClr      = 1'b1;
        if (input_valid) begin
          xWrEn = 1'b1;
          if (xIdx_q == COL_LAST) begin
            xIdx_d  = '0;
            cnt_d   = '0;
            state_d = COMPUTE;
          end else begin
            xIdx_d = xIdx_q + XW'(1);
          end
        end
      end
      COMPUTE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUT: begin
        // The first OUT cycle only loads the output register from the settled accumulators.
        if (!outValid_q) begin
          outValid_d = 1'b1;
          outData_d  = laneY[outLane_q];
        end else if (output_ready) begin
          if (outLane_q == LANE_LAST) begin
            outValid_d = 1'b0;
            outLane_d  = '0;
            if (pass_q == GRP_LAST) begin
              pass_d  = '0;
              state_d = X_LOAD;
            end else begin
              pass_d  = pass_q + GW'(1);
              accClr  = 1'b1;
              state_d = COMPUTE;
            end
          end else begin
            outLane_d = nextLane;
            outData_d = laneY[nextLane];
          end
        end
      end
      default: state_d = W_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= W_LOAD;
      col_q      <= '0;
      lane_q     <= '0;
      grp_q      <= '0;
      xIdx_q     <= '0;
      cnt_q      <= '0;
      pass_q     <= '0;
      outLane_q  <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      xCol_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      lane_q     <= lane_d;
      grp_q      <= grp_d;
      xIdx_q     <= xIdx_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      outLane_q  <= outLane_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      if (rdEn) xCol_q <= xBuf_q[cnt_q[XW-1:0]];
    end
  end

`ifdef FC_BIAS_EN
  always_ff @(posedge clk) begin
    if (reset) biasPhase_q <= 1'b0;
    else biasPhase_q <= biasPhase_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (xWrEn) xBuf_q[xIdx_q] <= input_data;
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    fc_mac_lane #(
      .N(N), .T(T), .GRPS(GRPS), .R(R), .AW(AW)
`ifdef FC_BIAS_EN
      , .GW(GW)
`endif
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .wrEn_i     (wrEn[g]),
      .wrAddr_i   (wrAddr),
      .wrData_i   (w_data),
`ifdef FC_BIAS_EN
      .biasWrEn_i (biasWrEn[g]),
      .biasWrIdx_i(grp_q),
      .biasSel_i  (pass_d),
`endif
      .rdEn_i     (rdEn),
      .rdAddr_i   (rdAddr),
      .x_i        (xCol_q),
      .accClr_i   (accClr),
      .y_o        (laneY[g])
    );
  end

  assign output_valid = outValid_q;
  assign output_data  = outData_q;

endmodule

// File: tb/tb_fc_par_layer.sv
// Scoreboard bench for fc_par_layer: a ReLU and an identity instance share all stimulus.
// Bias vectors are exercised when FC_BIAS_EN is defined.
module tb_fc_par_layer;

  localparam int M = 4;
  localparam int N = 3;
  localparam int T = 16;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         w_valid = 1'b0;
  logic [T-1:0] w_data = '0;
  logic         input_valid = 1'b0;
  logic [T-1:0] input_data = '0;
  logic         output_ready = 1'b1;

  logic         wReadyA, inReadyA, outValidA;
  logic [T-1:0] outDataA;
  logic         wReadyB, inReadyB, outValidB;
  logic [T-1:0] outDataB;

  int vectorCount = 0;
  int missCount = 0;

  logic [T-1:0] expRelu[$];
  logic [T-1:0] expLin[$];
  int wModel [M][N];
  int bModel [M];

  always #5 clk = ~clk;

  fc_par_layer #(.M(M), .N(N), .T(T), .P(P), .R(1)) dutRelu (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(wReadyA), .w_data(w_data),
    .input_valid(input_valid), .input_ready(inReadyA), .input_data(input_data),
    .output_valid(outValidA), .output_ready(output_ready), .output_data(outDataA)
  );

  fc_par_layer #(.M(M), .N(N), .T(T), .P(P), .R(0)) dutLin (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(wReadyB), .w_data(w_data),
    .input_valid(input_valid), .input_ready(inReadyB), .input_data(input_data),
    .output_valid(outValidB), .output_ready(output_ready), .output_data(outDataB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Expected rows, in stream order, are queued the moment a vector is driven.
  task automatic pushExpected(input int x[N]);
    int acc;
    for (int r = 0; r < M; r++) begin
      acc = bModel[r];
      for (int c = 0; c < N; c++)
        acc = sat16(longint'(acc) + longint'(sat16(longint'(wModel[r][c]) * longint'(x[c]))));
      expLin.push_back(16'(acc));
      expRelu.push_back((acc < 0) ? 16'd0 : 16'(acc));
    end
  endtask

  task automatic setWeights(input int val, input int row0);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        wModel[r][c] = (r == 0) ? row0 : val;
  endtask

  task automatic sendWord(input logic [T-1:0] d);
    int guard;
    @(negedge clk);
    w_valid = 1'b1;
    w_data  = d;
    guard   = 0;
    while (!wReadyA && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!wReadyA) checkOutput("w_ready wait", 32'(wReadyA), 32'd1);
    @(posedge clk);
  endtask

  task automatic loadWeights();
    for (int k = 0; k < M * N; k++) sendWord(16'(wModel[k / N][k % N]));
`ifdef FC_BIAS_EN
    for (int r = 0; r < M; r++) sendWord(16'(bModel[r]));
`endif
    #1;
    w_valid     = 1'b0;
    input_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int x[N]);
    int guard;
    pushExpected(x);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      input_valid = 1'b1;
      input_data  = 16'(x[i]);
      guard = 0;
      while (!inReadyA && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (!inReadyA) checkOutput("input_ready wait", 32'(inReadyA), 32'd1);
      @(posedge clk);
    end
    #1;
    input_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((expRelu.size() > 0 || expLin.size() > 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain relu", 32'(expRelu.size()), 32'd0);
    checkOutput("drain lin", 32'(expLin.size()), 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    expRelu.delete();
    expLin.delete();
  endtask

  // Handshakes complete on the following rising edge; checks happen on the falling edge before it.
  always @(negedge clk) begin
    if (!reset) begin
      if (outValidA && output_ready) begin
        if (expRelu.size() == 0) checkOutput("relu spurious valid", 32'(outValidA), 32'd0);
        else checkOutput("relu y", 32'(outDataA), 32'(expRelu.pop_front()));
      end
      if (outValidB && output_ready) begin
        if (expLin.size() == 0) checkOutput("lin spurious valid", 32'(outValidB), 32'd0);
        else checkOutput("lin y", 32'(outDataB), 32'(expLin.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int xv[N];
    int lat;
    int guard;

    for (int r = 0; r < M; r++) bModel[r] = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset w_ready", 32'(wReadyA), 32'd1);
    checkOutput("reset input_ready", 32'(inReadyA), 32'd0);
    checkOutput("reset output_valid", 32'(outValidA), 32'd0);
    checkOutput("reset output_data", 32'(outDataB), 32'd0);
    #1 reset = 1'b0;

    $display("[TB] all-ones weights and first-output latency");
    setWeights(1, 1);
    loadWeights();
    xv = '{1, 2, 3};
    applyStimulus(xv);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
      if (outValidA) break;
    end
    checkOutput("first valid latency", 32'(lat), 32'd6);
    waitDrain();

    $display("[TB] negative row 0");
    setWeights(1, -1);
    doReset();
    loadWeights();
    applyStimulus(xv);
    waitDrain();

    $display("[TB] saturation");
    setWeights(2, 2);
    doReset();
    loadWeights();
    xv = '{20000, 20000, 20000};
    applyStimulus(xv);
    waitDrain();
    setWeights(-2, -2);
    doReset();
    loadWeights();
    applyStimulus(xv);
    waitDrain();

    $display("[TB] output backpressure and weight reuse");
    setWeights(1, 1);
    doReset();
    loadWeights();
    @(posedge clk);
    #2 output_ready = 1'b0;
    xv = '{1, 2, 3};
    applyStimulus(xv);
    guard = 0;
    while (guard < 40) begin
      @(posedge clk);
      guard++;
      #1;
      if (outValidA) break;
    end
    checkOutput("stall first valid", 32'(outValidA), 32'd1);
    #1 output_ready = 1'b1;
    @(posedge clk);
    #2 output_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall valid", 32'(outValidA), 32'd1);
      checkOutput("stall data", 32'(outDataA), 32'd6);
    end
    @(posedge clk);
    #2 output_ready = 1'b1;
    waitDrain();
    xv = '{0, 0, 1};
    applyStimulus(xv);
    waitDrain();

    $display("[TB] reset during compute and stray input_valid");
    xv = '{1, 2, 3};
    applyStimulus(xv);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset w_ready", 32'(wReadyA), 32'd1);
    checkOutput("midreset input_ready", 32'(inReadyA), 32'd0);
    checkOutput("midreset output_valid", 32'(outValidB), 32'd0);
    #1 reset = 1'b0;
    expRelu.delete();
    expLin.delete();
    input_valid = 1'b1;
    input_data  = 16'h7fff;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stray input_ready", 32'(inReadyA), 32'd0);
    end
    loadWeights();
    applyStimulus(xv);
    waitDrain();

`ifdef FC_BIAS_EN
    $display("[TB] bias preload");
    bModel = '{10, -10, 0, 5};
    setWeights(1, 1);
    doReset();
    loadWeights();
    applyStimulus(xv);
    waitDrain();
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
